// File: rtl/ddma_mem_arbiter.sv
// ddma_mem_arbiter: round-robin single-port memory arbiter with burst grain; optional stats via DDMA_ARB_STATS_EN
module ddma_mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int GRAIN      = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic [$clog2(NUM_REQ)-1:0]       owner_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_data_o,
    output logic                             mem_wb_o,
    output logic                             mem_enable_o,
    input  logic [DATA_WIDTH-1:0]            mem_data_i
`ifdef DDMA_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]            grant_cnt_o,
    output logic [NUM_REQ*16-1:0]            max_wait_o,
    input  logic                             stats_clr_i
`endif
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int GW = $clog2(GRAIN + 1);

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

    arb_state_t      state, state_n;
    logic [OW-1:0]   owner, owner_n, ptr, ptr_n, first_ptr, next_own;
    logic [GW-1:0]   gcnt, gcnt_n;
    logic            granted, other;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign owner_o = owner;
    assign rdata_o = |rvalid_o ? mem_data_i : rdata_q;

    // round-robin search: first pending from ptr (inclusive) and first pending after owner
    always_comb begin
        first_ptr = ptr;
        next_own  = owner;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_i[(int'(ptr) + k) % NUM_REQ]) first_ptr = OW'((int'(ptr) + k) % NUM_REQ);
        for (int k = NUM_REQ - 1; k >= 1; k--)
            if (req_i[(int'(owner) + k) % NUM_REQ]) next_own = OW'((int'(owner) + k) % NUM_REQ);
    end

    // next-state, hand-over decision and memory-side outputs
    always_comb begin
        granted      = state == ARB_OWN && req_i[owner];
        other        = |(req_i & ~(NUM_REQ'(1) << owner));
        state_n      = state;
        owner_n      = owner;
        ptr_n        = ptr;
        gcnt_n       = gcnt;
        gnt_o        = granted ? NUM_REQ'(1) << owner : '0;
        mem_enable_o = granted;
        mem_wb_o     = granted && we_i[owner];
        mem_addr_o   = granted ? addr_i[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        mem_data_o   = granted ? wdata_i[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (state == ARB_IDLE) begin
            if (|req_i) begin
                state_n = ARB_OWN;
                owner_n = first_ptr;
                gcnt_n  = GW'(GRAIN);
            end
        end else if (other && (!granted || gcnt == GW'(1))) begin
            owner_n = next_own;
            gcnt_n  = GW'(GRAIN);
        end else if (!granted) begin
            state_n = ARB_IDLE;
            ptr_n   = OW'((int'(owner) + 1) % NUM_REQ);
        end else begin
            gcnt_n  = gcnt == GW'(1) ? gcnt : gcnt - GW'(1);
        end
    end

    // arbitration state plus read-return tag and held read data
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            ptr      <= '0;
            gcnt     <= GW'(GRAIN);
            rvalid_o <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            gcnt     <= gcnt_n;
            rvalid_o <= (granted && !we_i[owner]) ? gnt_o : '0;
            if (|rvalid_o) rdata_q <= mem_data_i;
        end
    end

`ifdef DDMA_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [31:0] gc;
        logic [15:0] mw, wc;
        assign grant_cnt_o[i*32 +: 32] = gc;
        assign max_wait_o[i*16 +: 16]  = mw;
        // saturating grant count, current wait length and longest wait seen
        always_ff @(posedge clock) begin
            if (reset || stats_clr_i) begin
                gc <= '0;
                mw <= '0;
                wc <= '0;
            end else if (gnt_o[i]) begin
                gc <= &gc ? gc : gc + 32'd1;
                mw <= wc > mw ? wc : mw;
                wc <= '0;
            end else begin
                wc <= !req_i[i] ? '0 : (&wc ? wc : wc + 16'd1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_ddma_mem_arbiter.sv
// tb_ddma_mem_arbiter: directed self-checking bench for ddma_mem_arbiter
module tb_ddma_mem_arbiter;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clock = 1'b0, reset = 1'b1;
    logic [1:0]  req_i = '0, we_i = '0;
    logic [63:0] addr_i = '0, wdata_i = '0;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o, mem_addr_o, mem_data_o;
    logic [0:0]  owner_o;
    logic        mem_wb_o, mem_enable_o;
    logic [31:0] mem_data_i = '0;
`ifdef DDMA_ARB_STATS_EN
    logic [63:0] grant_cnt_o;
    logic [31:0] max_wait_o;
    logic        stats_clr_i = 1'b0;
`endif
    int total = 0, bad = 0;

    ddma_mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .GRAIN(3)) dut (
        .clock(clock), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .owner_o(owner_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_wb_o(mem_wb_o), .mem_enable_o(mem_enable_o), .mem_data_i(mem_data_i)
`ifdef DDMA_ARB_STATS_EN
        , .grant_cnt_o(grant_cnt_o), .max_wait_o(max_wait_o), .stats_clr_i(stats_clr_i)
`endif
    );

    always #5 clock = ~clock;

    // synchronous-read memory: data for a read appears the cycle after it is enabled
    always @(posedge clock) if (mem_enable_o && !mem_wb_o) mem_data_i <= mem_addr_o ^ K;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_i = '0;
        we_i  = '0;
`ifdef DDMA_ARB_STATS_EN
        stats_clr_i = 1'b0;
`endif
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clock);
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
        total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL reset_rvalid got %b want 00", rvalid_o); end
        total++; if (owner_o !== 1'b0) begin bad++; $display("FAIL reset_owner got %0d want 0", owner_o); end
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
        total++; if ({mem_enable_o, mem_wb_o} !== 2'b00) begin bad++; $display("FAIL reset_mem_ctl got %b want 00", {mem_enable_o, mem_wb_o}); end
        total++; if ({mem_addr_o, mem_data_o} !== 64'h0) begin bad++; $display("FAIL reset_mem_bus got %h want 0", {mem_addr_o, mem_data_o}); end
        tick;
    endtask

    task automatic test_single;
        do_reset;
        addr_i = {32'h0, 32'h10};
        req_i  = 2'b01;
        @(negedge clock);
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL single_idle_gnt got %b want 00", gnt_o); end
        tick;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clock);
            total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL single_gnt c%0d got %b want 01", n, gnt_o); end
            total++; if (mem_addr_o !== 32'h10 || mem_enable_o !== 1'b1 || mem_wb_o !== 1'b0) begin bad++; $display("FAIL single_mem c%0d got %h/%b/%b want 10/1/0", n, mem_addr_o, mem_enable_o, mem_wb_o); end
            total++; if (owner_o !== 1'b0) begin bad++; $display("FAIL single_owner c%0d got %0d want 0", n, owner_o); end
            total++; if (rvalid_o !== (n > 1 ? 2'b01 : 2'b00)) begin bad++; $display("FAIL single_rvalid c%0d got %b want %b", n, rvalid_o, n > 1 ? 2'b01 : 2'b00); end
            if (n > 1) begin
                total++; if (rdata_o !== (32'h10 ^ K)) begin bad++; $display("FAIL single_rdata c%0d got %h want %h", n, rdata_o, 32'h10 ^ K); end
            end
            tick;
        end
        req_i = 2'b00;
        @(negedge clock);
        total++; if (gnt_o !== 2'b00 || rvalid_o !== 2'b01) begin bad++; $display("FAIL single_tail got gnt=%b rvalid=%b want 00/01", gnt_o, rvalid_o); end
        total++; if (rdata_o !== (32'h10 ^ K)) begin bad++; $display("FAIL single_tail_rdata got %h want %h", rdata_o, 32'h10 ^ K); end
        tick;
    endtask

    task automatic test_contention;
        int pat [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        logic [31:0] last;
        logic [1:0]  eg, er;
        last = 32'h0;
        do_reset;
        addr_i  = {32'h200, 32'h100};
        wdata_i = {32'hB, 32'hA};
        we_i    = 2'b01;
        req_i   = 2'b11;
        @(negedge clock);
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL cont_idle_gnt got %b want 00", gnt_o); end
        tick;
        for (int c = 0; c < 10; c++) begin
            eg = pat[c] == 1 ? 2'b10 : 2'b01;
            er = (c > 0 && pat[c-1] == 1) ? 2'b10 : 2'b00;
            if (er == 2'b10) last = 32'h200 ^ K;
            @(negedge clock);
            total++; if (gnt_o !== eg) begin bad++; $display("FAIL cont_gnt c%0d got %b want %b", c, gnt_o, eg); end
            total++; if (mem_addr_o !== (pat[c] == 1 ? 32'h200 : 32'h100)) begin bad++; $display("FAIL cont_addr c%0d got %h", c, mem_addr_o); end
            total++; if (mem_wb_o !== (pat[c] == 0) || mem_data_o !== (pat[c] == 1 ? 32'hB : 32'hA)) begin bad++; $display("FAIL cont_wr c%0d got wb=%b data=%h", c, mem_wb_o, mem_data_o); end
            total++; if (rvalid_o !== er) begin bad++; $display("FAIL cont_rvalid c%0d got %b want %b", c, rvalid_o, er); end
            total++; if (rdata_o !== last) begin bad++; $display("FAIL cont_rdata c%0d got %h want %h", c, rdata_o, last); end
            tick;
        end
    endtask

    task automatic test_drop;
        do_reset;
        addr_i = {32'h200, 32'h100};
        req_i  = 2'b11;
        tick;
        @(negedge clock);
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL drop_first got %b want 01", gnt_o); end
        tick;
        req_i = 2'b10;
        @(negedge clock);
        total++; if (gnt_o !== 2'b00 || owner_o !== 1'b0) begin bad++; $display("FAIL drop_gap got gnt=%b owner=%0d want 00/0", gnt_o, owner_o); end
        tick;
        req_i = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            total++; if (gnt_o !== 2'b10 || owner_o !== 1'b1) begin bad++; $display("FAIL drop_burst c%0d got gnt=%b owner=%0d want 10/1", c, gnt_o, owner_o); end
            tick;
        end
        @(negedge clock);
        total++; if (gnt_o !== 2'b01 || owner_o !== 1'b0) begin bad++; $display("FAIL drop_back got gnt=%b owner=%0d want 01/0", gnt_o, owner_o); end
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        addr_i = {32'h300, 32'h0};
        req_i  = 2'b10;
        tick;
        @(negedge clock);
        total++; if (gnt_o !== 2'b10 || owner_o !== 1'b1) begin bad++; $display("FAIL mid_gnt got gnt=%b owner=%0d want 10/1", gnt_o, owner_o); end
        tick;
        @(negedge clock);
        total++; if (rvalid_o !== 2'b10 || rdata_o !== (32'h300 ^ K)) begin bad++; $display("FAIL mid_read got %b/%h want 10/%h", rvalid_o, rdata_o, 32'h300 ^ K); end
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clock);
        total++; if (gnt_o !== 2'b00 || rvalid_o !== 2'b00 || owner_o !== 1'b0) begin bad++; $display("FAIL mid_after got gnt=%b rvalid=%b owner=%0d want 00/00/0", gnt_o, rvalid_o, owner_o); end
        tick;
        @(negedge clock);
        total++; if (gnt_o !== 2'b10 || owner_o !== 1'b1) begin bad++; $display("FAIL mid_regrant got gnt=%b owner=%0d want 10/1", gnt_o, owner_o); end
        reset = 1'b1;
        req_i = 2'b11;
        tick;
        reset = 1'b0;
        tick;
        @(negedge clock);
        total++; if (gnt_o !== 2'b01 || owner_o !== 1'b0) begin bad++; $display("FAIL mid_ptr0 got gnt=%b owner=%0d want 01/0", gnt_o, owner_o); end
        tick;
    endtask

`ifdef DDMA_ARB_STATS_EN
    task automatic test_stats;
        do_reset;
        addr_i = {32'h200, 32'h100};
        req_i  = 2'b11;
        for (int c = 0; c < 11; c++) tick;
        stats_clr_i = 1'b1;
        @(negedge clock);
        total++; if (grant_cnt_o !== {32'd4, 32'd6}) begin bad++; $display("FAIL stats_cnt got %h want 4/6", grant_cnt_o); end
        total++; if (max_wait_o !== {16'd4, 16'd3}) begin bad++; $display("FAIL stats_wait got %h want 4/3", max_wait_o); end
        tick;
        stats_clr_i = 1'b0;
        req_i = 2'b00;
        @(negedge clock);
        total++; if (grant_cnt_o !== 64'h0 || max_wait_o !== 32'h0) begin bad++; $display("FAIL stats_clr got %h/%h want 0/0", grant_cnt_o, max_wait_o); end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_drop;
        test_reset_mid;
`ifdef DDMA_ARB_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
